// File: rtl/echo_gate_demod_pkg.sv
// Shared types and carrier constants for the echo range-gate demodulator.
package echo_gate_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ACQ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] P_F8 = 6'd8;
    localparam logic [5:0] P_F4 = 6'd16;
    localparam logic [5:0] P_F2 = 6'd32;
    localparam logic [2:0] K_F8 = 3'd2;
    localparam logic [2:0] K_F4 = 3'd3;
    localparam logic [2:0] K_F2 = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [2:0] k;
    } sel_t;

    function automatic sel_t sel_to_k(input logic f8, input logic f4, input logic f2);
        sel_t s;
        s.valid = 1'b1;
        case ({f8, f4, f2})
            3'b100:  s.k = K_F8;
            3'b010:  s.k = K_F4;
            3'b001:  s.k = K_F2;
            default: begin
                s.valid = 1'b0;
                s.k     = K_F8;
            end
        endcase
        return s;
    endfunction

    function automatic logic [5:0] k_to_period(input logic [2:0] k);
        logic [5:0] p;
        case (k)
            K_F8:    p = P_F8;
            K_F4:    p = P_F4;
            K_F2:    p = P_F2;
            default: p = P_F8;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/echo_gate_demod_carrier_ref.sv
// Square-wave I/Q reference signs derived from the latency-compensated burst phase.
module carrier_ref (
    input  logic [4:0] i_ph_d,
    input  logic [2:0] i_k,
    output logic       o_si_neg,
    output logic       o_sq_neg
);

    // I follows the carrier half-cycle bit; Q leads by a quarter period
    always_comb begin
        o_si_neg = i_ph_d[i_k];
        o_sq_neg = i_ph_d[i_k] ^ i_ph_d[i_k - 3'd1];
    end

endmodule

// File: rtl/echo_gate_demod.sv
// Range-gated quadrature demodulator: delay after START, integrate ADC echo, emit one I/Q pair.
module echo_gate_demod
    import echo_gate_pkg::*;
#(
    parameter int ADC_W   = 10,
    parameter int ACC_W   = 24,
    parameter int DLY_W   = 12,
    parameter int LEN_W   = 8,
    parameter int ADC_LAT = 3
) (
    input  logic             CLK64,
    input  logic             RES_n,
    input  logic             F8,
    input  logic             F4,
    input  logic             F2,
    input  logic             START,
    input  logic [DLY_W-1:0] GATE_DLY,
    input  logic [LEN_W-1:0] GATE_LEN,
    input  logic [ADC_W-1:0] ADC_D,
    output logic             ADC_EN,
    output logic             SMPL_EN,
    output logic             BUSY,
    output logic             ERR,
    output logic             IQ_VALID,
    output logic [ACC_W-1:0] I_OUT,
    output logic [ACC_W-1:0] Q_OUT
);

    // Wide enough for the longest burst (max delay + latency + 255 periods of 32)
    localparam int T_W = ((DLY_W > LEN_W + 5) ? DLY_W : LEN_W + 5) + 1;
    localparam logic [T_W-1:0] T_ONE = {{(T_W-1){1'b0}}, 1'b1};
    localparam logic [T_W-1:0] T_LAT = T_W'(ADC_LAT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [T_W-1:0]   r_t;
    logic [T_W-1:0]   r_open;
    logic [T_W-1:0]   r_close;
    logic [2:0]       r_k;
    logic [ACC_W-1:0] r_acc_i;
    logic [ACC_W-1:0] r_acc_q;
    logic             r_adc_en;
    logic             r_smpl_en;
    logic             r_busy;
    logic             r_err;
    logic             r_iq_valid;
    logic [ACC_W-1:0] r_i_out;
    logic [ACC_W-1:0] r_q_out;

    sel_t             w_sel;
    logic             w_cfg_ok;
    logic             w_accept;
    logic             w_reject;
    logic [T_W-1:0]   w_open_in;
    logic [T_W-1:0]   w_n_in;
    logic [T_W-1:0]   w_t_inc;
    logic             w_last;
    logic             w_in_win_nxt;
    logic [4:0]       w_ph_d;
    logic             w_si_neg;
    logic             w_sq_neg;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum_i;
    logic [ACC_W-1:0] w_sum_q;

    assign w_sel     = sel_to_k(F8, F4, F2);
    assign w_cfg_ok  = w_sel.valid && (GATE_LEN != {LEN_W{1'b0}});
    assign w_accept  = START && (r_state == S_IDLE) && w_cfg_ok;
    assign w_reject  = START && (r_state == S_IDLE) && !w_cfg_ok;
    assign w_open_in = T_W'(GATE_DLY) + T_LAT;
    assign w_n_in    = T_W'(GATE_LEN) * T_W'(k_to_period(w_sel.k));
    assign w_t_inc   = r_t + T_ONE;
    assign w_last    = (r_state == S_ACQ) && (w_t_inc == r_close);
    // The sample request window runs ADC_LAT cycles ahead of the accumulation window
    assign w_in_win_nxt = (w_t_inc >= (r_open - T_LAT)) && (w_t_inc < (r_close - T_LAT));

    // r_t low bits are the burst phase; subtracting the latency gives the sample's phase
    assign w_ph_d = r_t[4:0] - 5'(ADC_LAT);

    carrier_ref u_carrier_ref (
        .i_ph_d   (w_ph_d),
        .i_k      (r_k),
        .o_si_neg (w_si_neg),
        .o_sq_neg (w_sq_neg)
    );

    assign w_ext   = {{(ACC_W-ADC_W){ADC_D[ADC_W-1]}}, ADC_D};
    assign w_sum_i = w_si_neg ? (r_acc_i - w_ext) : (r_acc_i + w_ext);
    assign w_sum_q = w_sq_neg ? (r_acc_q - w_ext) : (r_acc_q + w_ext);

    // State register
    always_ff @(posedge CLK64 or negedge RES_n) begin
        if (!RES_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_DELAY;
                else          w_state_nxt = S_IDLE;
            end
            S_DELAY: begin
                if (w_t_inc == r_open) w_state_nxt = S_ACQ;
                else                   w_state_nxt = S_DELAY;
            end
            S_ACQ: begin
                if (w_last) w_state_nxt = S_DONE;
                else        w_state_nxt = S_ACQ;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst timer, latched configuration and I/Q accumulators
    always_ff @(posedge CLK64 or negedge RES_n) begin
        if (!RES_n) begin
            r_t     <= {T_W{1'b0}};
            r_open  <= {T_W{1'b0}};
            r_close <= {T_W{1'b0}};
            r_k     <= K_F8;
            r_acc_i <= {ACC_W{1'b0}};
            r_acc_q <= {ACC_W{1'b0}};
        end else if (w_accept) begin
            r_t     <= T_ONE;
            r_open  <= w_open_in;
            r_close <= w_open_in + w_n_in;
            r_k     <= w_sel.k;
            r_acc_i <= {ACC_W{1'b0}};
            r_acc_q <= {ACC_W{1'b0}};
        end else if (r_state != S_IDLE) begin
            r_t <= w_t_inc;
            if (r_state == S_ACQ) begin
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end
        end
    end

    // Registered status and result outputs
    always_ff @(posedge CLK64 or negedge RES_n) begin
        if (!RES_n) begin
            r_adc_en   <= 1'b0;
            r_smpl_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_iq_valid <= 1'b0;
            r_i_out    <= {ACC_W{1'b0}};
            r_q_out    <= {ACC_W{1'b0}};
        end else begin
            r_adc_en   <= (w_state_nxt != S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_iq_valid <= w_last;
            if (w_accept) begin
                r_smpl_en <= (GATE_DLY == {DLY_W{1'b0}});
            end else begin
                r_smpl_en <= ((r_state == S_DELAY) || (r_state == S_ACQ)) && w_in_win_nxt;
            end
            if (w_accept)      r_err <= 1'b0;
            else if (w_reject) r_err <= 1'b1;
            if (w_last) begin
                r_i_out <= w_sum_i;
                r_q_out <= w_sum_q;
            end
        end
    end

    assign ADC_EN   = r_adc_en;
    assign SMPL_EN  = r_smpl_en;
    assign BUSY     = r_busy;
    assign ERR      = r_err;
    assign IQ_VALID = r_iq_valid;
    assign I_OUT    = r_i_out;
    assign Q_OUT    = r_q_out;

endmodule

// File: tb/tb_echo_gate_demod.sv
// Self-checking bench for echo_gate_demod: table-driven bursts with a result scoreboard.
module tb_echo_gate_demod;

    localparam int ADC_W   = 10;
    localparam int ACC_W   = 24;
    localparam int DLY_W   = 12;
    localparam int LEN_W   = 8;
    localparam int ADC_LAT = 3;

    logic             CLK64 = 1'b0;
    logic             RES_n;
    logic             F8, F4, F2, START;
    logic [DLY_W-1:0] GATE_DLY;
    logic [LEN_W-1:0] GATE_LEN;
    logic [ADC_W-1:0] ADC_D;
    logic             ADC_EN, SMPL_EN, BUSY, ERR, IQ_VALID;
    logic [ACC_W-1:0] I_OUT, Q_OUT;

    typedef struct {
        int     sel;    // 0=F8 1=F4 2=F2
        int     dly;
        int     len;
        int     pat;    // 0 I-tone, 1 Q-tone, 2 DC, 3 random (modelled)
        int     amp;
        longint exp_i;
        longint exp_q;
        int     inj_t;  // cycle of an extra START that must be ignored, -1 none
    } vec_t;

    typedef struct {
        longint i;
        longint q;
        int     t;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_tests = 0;
    int   n_fail  = 0;

    echo_gate_demod dut (
        .CLK64    (CLK64),
        .RES_n    (RES_n),
        .F8       (F8),
        .F4       (F4),
        .F2       (F2),
        .START    (START),
        .GATE_DLY (GATE_DLY),
        .GATE_LEN (GATE_LEN),
        .ADC_D    (ADC_D),
        .ADC_EN   (ADC_EN),
        .SMPL_EN  (SMPL_EN),
        .BUSY     (BUSY),
        .ERR      (ERR),
        .IQ_VALID (IQ_VALID),
        .I_OUT    (I_OUT),
        .Q_OUT    (Q_OUT)
    );

    always #5 CLK64 = ~CLK64;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK64);
        #1;
    endtask

    function automatic int ref_sign(input int sel, input int t, input int quad);
        int r, k, b;
        r = (t + 32 - ADC_LAT) % 32;
        k = 2 + sel;
        if (quad != 0) b = ((r >> k) ^ (r >> (k - 1))) & 1;
        else           b = (r >> k) & 1;
        return (b != 0) ? -1 : 1;
    endfunction

    function automatic longint sgn_i();
        longint v;
        v = $signed(I_OUT);
        return v;
    endfunction

    function automatic longint sgn_q();
        longint v;
        v = $signed(Q_OUT);
        return v;
    endfunction

    task automatic run_burst(input vec_t v);
        int     n, t_done, nvalid, smpl_cnt, smpl_first, smpl_last, x;
        longint mi, mq, held_i, held_q;
        exp_t   e;
        logic [2:0] fsel;
        n      = v.len * (8 << v.sel);
        t_done = v.dly + ADC_LAT + n;
        nvalid = 0; smpl_cnt = 0; smpl_first = -1; smpl_last = -1;
        mi = 0; mq = 0; held_i = 0; held_q = 0;
        fsel = 3'b100 >> v.sel;
        step();
        START    = 1'b1;
        {F8, F4, F2} = fsel;
        GATE_DLY = v.dly[DLY_W-1:0];
        GATE_LEN = v.len[LEN_W-1:0];
        ADC_D    = '0;
        if (v.pat != 3) sb.push_back('{v.exp_i, v.exp_q, t_done});
        for (int t = 1; t <= t_done + 3; t++) begin
            step();
            START = 1'b0;
            if (t == 1) begin
                {F8, F4, F2} = ~fsel;
                check("busy_rise", BUSY, 1);
                check("adc_en_rise", ADC_EN, 1);
                check("err_after_accept", ERR, 0);
            end
            if (t == v.inj_t) begin
                START = 1'b1; {F8, F4, F2} = 3'b100; GATE_DLY = '0; GATE_LEN = 8'd1;
            end
            if (SMPL_EN) begin
                smpl_cnt++;
                if (smpl_first < 0) smpl_first = t;
                smpl_last = t;
            end
            if (IQ_VALID) begin
                nvalid++;
                if (sb.size() == 0) begin
                    check("scoreboard_empty_on_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("i_out", sgn_i(), e.i);
                    check("q_out", sgn_q(), e.q);
                    check("iq_valid_time", t, e.t);
                    held_i = e.i; held_q = e.q;
                end
            end
            if (t == t_done) check("busy_at_done", BUSY, 1);
            if (t == t_done + 1) begin
                check("busy_fall", BUSY, 0);
                check("adc_en_fall", ADC_EN, 0);
            end
            if (t == t_done + 3 && nvalid == 1) begin
                check("i_out_hold", sgn_i(), held_i);
                check("q_out_hold", sgn_q(), held_q);
            end
            case (v.pat)
                0:       x = v.amp * ref_sign(v.sel, t, 0);
                1:       x = v.amp * ref_sign(v.sel, t, 1);
                2:       x = v.amp;
                default: x = $urandom_range(0, 1023) - 512;
            endcase
            ADC_D = x[ADC_W-1:0];
            if (v.pat == 3 && t >= v.dly + ADC_LAT && t < t_done) begin
                mi += x * ref_sign(v.sel, t, 0);
                mq += x * ref_sign(v.sel, t, 1);
                if (t == t_done - 1) sb.push_back('{mi, mq, t_done});
            end
        end
        check("iq_valid_count", nvalid, 1);
        if (v.dly > 0) begin
            check("smpl_en_count", smpl_cnt, n);
            check("smpl_en_first", smpl_first, v.dly);
            check("smpl_en_last", smpl_last, v.dly + n - 1);
        end
    endtask

    task automatic bad_start(input logic [2:0] f, input int len);
        int nv, busy_seen;
        nv = 0; busy_seen = 0;
        step();
        START = 1'b1; {F8, F4, F2} = f; GATE_LEN = len[LEN_W-1:0]; GATE_DLY = 12'd5;
        for (int i = 0; i < 12; i++) begin
            step();
            START = 1'b0;
            if (BUSY) busy_seen = 1;
            if (IQ_VALID) nv++;
        end
        check("err_set", ERR, 1);
        check("busy_after_reject", busy_seen, 0);
        check("iq_valid_after_reject", nv, 0);
    endtask

    initial begin
        int nv, busy_seen;
        vecs[0] = '{0, 20,   4, 0,  100,    3200,     0, -1};
        vecs[1] = '{0, 20,   4, 1,  100,       0,  3200, -1};
        vecs[2] = '{2,  5,   3, 2, -512,       0,     0, -1};
        vecs[3] = '{1, 10,   2, 0,   50,    1600,     0, 30};
        vecs[4] = '{1,  0,   1, 0,   -7,    -112,     0, -1};
        vecs[5] = '{2, 100,  2, 1,  511,       0, 32704, -1};
        vecs[6] = '{0, 33,   5, 3,    0,       0,     0, -1};
        vecs[7] = '{2,  7, 255, 0,  511, 4169760,     0, -1};
        vecs[8] = '{0, 4095, 1, 1, -300,       0, -2400, -1};

        RES_n = 1'b0; START = 1'b0; {F8, F4, F2} = 3'b100;
        GATE_DLY = '0; GATE_LEN = '0; ADC_D = '0;
        repeat (3) step();
        check("rst_adc_en", ADC_EN, 0);
        check("rst_smpl_en", SMPL_EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0);
        check("rst_iq_valid", IQ_VALID, 0);
        check("rst_i_out", sgn_i(), 0);
        check("rst_q_out", sgn_q(), 0);
        RES_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 9; i++) run_burst(vecs[i]);

        bad_start(3'b110, 4);
        run_burst(vecs[3]);
        bad_start(3'b100, 0);
        bad_start(3'b000, 4);

        // Reset during acquisition (ACQ spans t=13..44 for this setup)
        step();
        START = 1'b1; {F8, F4, F2} = 3'b010; GATE_DLY = 12'd10; GATE_LEN = 8'd2;
        ADC_D = 10'd77;
        for (int t = 1; t <= 30; t++) begin
            step();
            START = 1'b0;
        end
        check("pre_reset_busy", BUSY, 1);
        RES_n = 1'b0;
        #2;
        check("arst_adc_en", ADC_EN, 0);
        check("arst_smpl_en", SMPL_EN, 0);
        check("arst_busy", BUSY, 0);
        check("arst_err", ERR, 0);
        check("arst_iq_valid", IQ_VALID, 0);
        check("arst_i_out", sgn_i(), 0);
        check("arst_q_out", sgn_q(), 0);
        repeat (2) step();
        RES_n = 1'b1;
        nv = 0; busy_seen = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (IQ_VALID) nv++;
            if (BUSY) busy_seen = 1;
        end
        check("post_reset_no_valid", nv, 0);
        check("post_reset_idle", busy_seen, 0);
        run_burst(vecs[1]);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
